// File: rtl/sweep_pkg.sv
// Shared types and defaults for the sweep response checker.
package sweep_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    FINISH = 2'd3
  } state_t;

  localparam int DEF_N_IN          = 5;
  localparam int DEF_SETTLE_CYCLES = 2;
  // Settle counter width; covers the legal 0..15 settle range.
  localparam int SETTLE_W          = 4;
endpackage

// File: rtl/sweep_response_checker_settle_timer.sv
// Settle timer: load a cycle count, count down, pulse expire on the last cycle.
module settle_timer
  import sweep_pkg::*;
#(
  parameter int W = SETTLE_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] cycles,
  output logic         expire
);
  logic [W-1:0] cnt;

  // Counter holds the remaining wait cycles, including the current one.
  always_ff @(posedge clk) begin
    if (rst)             cnt <= '0;
    else if (load)       cnt <= cycles;
    else if (cnt != '0)  cnt <= cnt - W'(1);
  end

  // Expire during the final counted cycle so the consumer can leave on the next edge.
  always_comb begin
    expire = (cnt == W'(1));
  end
endmodule

// File: rtl/sweep_response_checker.sv
// Sweeps every stimulus vector, compares the DUT response to a latched
// golden truth table and reports mismatch count, first failing index and pass.
module sweep_response_checker
  import sweep_pkg::*;
#(
  parameter int N_IN          = DEF_N_IN,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [(1<<N_IN)-1:0] expected,
  input  logic                 resp,
  output logic [N_IN-1:0]      stim,
  output logic                 stim_valid,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [N_IN:0]        err_count,
  output logic [N_IN-1:0]      first_fail,
  output logic                 first_fail_valid
);
  localparam int                  NV        = 1 << N_IN;
  localparam logic [N_IN-1:0]     LAST_IDX  = '1;
  localparam logic [SETTLE_W-1:0] SETTLE_LD = SETTLE_W'(SETTLE_CYCLES);
  localparam bit                  NO_SETTLE = (SETTLE_CYCLES == 0);

  state_t          state, state_nxt;
  logic [N_IN-1:0] idx;
  logic [NV-1:0]   exp_lat;
  logic            mismatch;
  logic            last;
  logic [N_IN:0]   err_nxt;
  logic            timer_load;
  logic            timer_expire;

  // Load the timer on every entry into DRIVE.
  assign timer_load = (state_nxt == DRIVE) && (state != DRIVE);

  settle_timer #(.W(SETTLE_W)) u_settle (
    .clk    (clk),
    .rst    (rst),
    .load   (timer_load),
    .cycles (SETTLE_LD),
    .expire (timer_expire)
  );

  // Compare only in SAMPLE; err_nxt includes the current sample so pass sees the final one.
  always_comb begin
    mismatch = (state == SAMPLE) && (resp != exp_lat[idx]);
    last     = (idx == LAST_IDX);
    err_nxt  = err_count + (N_IN+1)'(mismatch);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; a zero settle time bypasses DRIVE entirely.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = NO_SETTLE ? SAMPLE : DRIVE;
      DRIVE:   if (timer_expire) state_nxt = SAMPLE;
      SAMPLE:  if (last) state_nxt = FINISH;
               else      state_nxt = NO_SETTLE ? SAMPLE : DRIVE;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state and the index register.
  always_comb begin
    stim       = idx;
    stim_valid = (state == DRIVE) || (state == SAMPLE);
    busy       = (state != IDLE);
    done       = (state == FINISH);
  end

  // Sweep datapath: latch table at start, accumulate results in SAMPLE, hold in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx              <= '0;
      exp_lat          <= '0;
      err_count        <= '0;
      first_fail       <= '0;
      first_fail_valid <= 1'b0;
      pass             <= 1'b0;
    end else if (state == IDLE && start) begin
      idx              <= '0;
      exp_lat          <= expected;
      err_count        <= '0;
      first_fail       <= '0;
      first_fail_valid <= 1'b0;
      pass             <= 1'b0;
    end else if (state == SAMPLE) begin
      err_count <= err_nxt;
      if (mismatch && !first_fail_valid) begin
        first_fail       <= idx;
        first_fail_valid <= 1'b1;
      end
      if (last) pass <= (err_nxt == '0);
      else      idx  <= idx + N_IN'(1);
    end
  end
endmodule

// File: tb/tb_sweep_response_checker.sv
// Directed, table-driven bench for sweep_response_checker (default and zero-settle builds).
module tb_sweep_response_checker;
  logic        clk, rst;
  logic        start0, start1;
  logic [31:0] exp0, exp1;
  logic        resp0, resp1;
  logic [4:0]  stim0, stim1, ff0, ff1;
  logic        sv0, sv1, busy0, busy1, done0, done1, pass0, pass1, ffv0, ffv1;
  logic [5:0]  err0, err1;

  // Response model controls shared by both instances (only one sweeps at a time).
  logic       sel, r_stuck, r_hi, r_flip_en;
  logic [4:0] r_flip;

  int n_pass = 0;
  int n_tot  = 0;

  sweep_response_checker dut (
    .clk(clk), .rst(rst), .start(start1), .expected(exp1), .resp(resp1),
    .stim(stim1), .stim_valid(sv1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .first_fail(ff1), .first_fail_valid(ffv1)
  );

  sweep_response_checker #(.SETTLE_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .expected(exp0), .resp(resp0),
    .stim(stim0), .stim_valid(sv0), .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err0), .first_fail(ff0), .first_fail_valid(ffv0)
  );

  assign resp1 = r_stuck ? 1'b0 : ((r_hi ? stim1[4] : stim1[0]) ^ (r_flip_en && stim1 == r_flip));
  assign resp0 = r_stuck ? 1'b0 : ((r_hi ? stim0[4] : stim0[0]) ^ (r_flip_en && stim0 == r_flip));

  logic [4:0] m_stim, m_ff;
  logic       m_sv, m_busy, m_done, m_pass, m_ffv;
  logic [5:0] m_err;
  assign m_stim = sel ? stim0 : stim1;
  assign m_sv   = sel ? sv0   : sv1;
  assign m_busy = sel ? busy0 : busy1;
  assign m_done = sel ? done0 : done1;
  assign m_pass = sel ? pass0 : pass1;
  assign m_err  = sel ? err0  : err1;
  assign m_ff   = sel ? ff0   : ff1;
  assign m_ffv  = sel ? ffv0  : ffv1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          sel0;      // 1: zero-settle instance
    logic [31:0] pattern;
    bit          stuck;     // resp stuck at 0
    bit          hi;        // resp = stim[4] (else stim[0])
    bit          flip_en;
    int          flip;      // stimulus index where resp is inverted
    int          restart;   // stim index at which start is re-pulsed (-1 none)
    bit          fin_start; // pulse start during the done cycle
    int          lat;
    int          err;
    int          ff;
    bit          ffv;
    bit          pass;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input int act, input int req);
    n_tot++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", name, act, req);
  endtask

  task automatic set_start(input bit s0, input logic v);
    if (s0) start0 = v;
    else    start1 = v;
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int         cyc, lat, nvalid, settle;
    logic [4:0] eidx;
    bit         bad, restarted;
    settle = v.sel0 ? 0 : 2;
    sel = v.sel0; r_stuck = v.stuck; r_hi = v.hi; r_flip_en = v.flip_en; r_flip = 5'(v.flip);
    @(negedge clk);
    if (v.sel0) exp0 = v.pattern; else exp1 = v.pattern;
    set_start(v.sel0, 1'b1);
    @(negedge clk);
    // Scramble the table after acceptance; the sweep must use the latched copy.
    start0 = 0; start1 = 0; exp0 = ~v.pattern; exp1 = ~v.pattern;
    cyc = 1; lat = -1; nvalid = 0; eidx = 0; bad = 0; restarted = 0;
    while (cyc <= 300) begin
      start0 = 0; start1 = 0;
      if (cyc == 1) begin
        chk($sformatf("v%0d first_stim", id), int'(m_stim), 0);
        chk($sformatf("v%0d first_valid", id), int'(m_sv), 1);
      end
      if (m_sv) begin
        nvalid++;
        if ({1'b0, m_stim} == {1'b0, eidx} + 6'd1) eidx = eidx + 5'd1;
        else if (m_stim != eidx) bad = 1;
      end
      if (m_done) begin lat = cyc; break; end
      if (v.restart >= 0 && !restarted && m_sv && m_stim == 5'(v.restart)) begin
        set_start(v.sel0, 1'b1);
        restarted = 1;
      end
      @(negedge clk);
      cyc++;
    end
    if (v.fin_start) set_start(v.sel0, 1'b1);
    chk($sformatf("v%0d latency", id), lat, v.lat);
    chk($sformatf("v%0d busy_at_done", id), int'(m_busy), 1);
    chk($sformatf("v%0d err_count", id), int'(m_err), v.err);
    chk($sformatf("v%0d first_fail", id), int'(m_ff), v.ff);
    chk($sformatf("v%0d first_fail_valid", id), int'(m_ffv), int'(v.ffv));
    chk($sformatf("v%0d pass", id), int'(m_pass), int'(v.pass));
    chk($sformatf("v%0d idx_seq", id), int'({bad, eidx}), 31);
    chk($sformatf("v%0d valid_cycles", id), nvalid, 32 * (settle + 1));
    @(negedge clk);
    start0 = 0; start1 = 0;
    chk($sformatf("v%0d done_one_cycle", id), int'(m_done), 0);
    chk($sformatf("v%0d busy_after", id), int'(m_busy), 0);
    chk($sformatf("v%0d valid_after", id), int'(m_sv), 0);
    repeat (3) @(negedge clk);
    chk($sformatf("v%0d err_hold", id), int'(m_err), v.err);
    chk($sformatf("v%0d ff_hold", id), int'(m_ff), v.ff);
    chk($sformatf("v%0d pass_hold", id), int'(m_pass), int'(v.pass));
    chk($sformatf("v%0d idle_busy", id), int'(m_busy), 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " stim"}, int'(m_stim), 0);
    chk({tag, " stim_valid"}, int'(m_sv), 0);
    chk({tag, " busy"}, int'(m_busy), 0);
    chk({tag, " done"}, int'(m_done), 0);
    chk({tag, " pass"}, int'(m_pass), 0);
    chk({tag, " err_count"}, int'(m_err), 0);
    chk({tag, " first_fail"}, int'(m_ff), 0);
    chk({tag, " first_fail_valid"}, int'(m_ffv), 0);
  endtask

  initial begin
    int  n_done;
    bit  found;
    //          sel0 pattern       stk hi flp idx rst fin lat err ff ffv pass
    vecs[0] = '{1'b0, 32'hFFFF0000, 0, 1, 0,  0, -1, 0, 97,  0, 0, 0, 1};
    vecs[1] = '{1'b0, 32'hFFFF0000, 0, 1, 1,  5, -1, 0, 97,  1, 5, 1, 0};
    vecs[2] = '{1'b0, 32'hFFFFFFFF, 1, 1, 0,  0, -1, 0, 97, 32, 0, 1, 0};
    vecs[3] = '{1'b0, 32'hFFFF0000, 0, 1, 0,  0, 10, 1, 97,  0, 0, 0, 1};
    vecs[4] = '{1'b0, 32'hFFFF0000, 0, 0, 0,  0, -1, 0, 97, 16, 1, 1, 0};
    vecs[5] = '{1'b0, 32'hFFFF0000, 0, 1, 1, 31, -1, 0, 97,  1,31, 1, 0};
    vecs[6] = '{1'b0, 32'h0000FFFF, 0, 1, 0,  0, -1, 0, 97, 32, 0, 1, 0};
    vecs[7] = '{1'b1, 32'hAAAAAAAA, 0, 0, 0,  0, -1, 0, 33,  0, 0, 0, 1};
    vecs[8] = '{1'b1, 32'hAAAAAAAA, 0, 0, 1,  0, -1, 0, 33,  1, 0, 1, 0};

    rst = 1; start0 = 0; start1 = 0; exp0 = '0; exp1 = '0;
    sel = 0; r_stuck = 0; r_hi = 1; r_flip_en = 0; r_flip = '0;
    repeat (2) @(negedge clk);
    sel = 0; chk_zero("reset dut");
    sel = 1; chk_zero("reset dut0");
    rst = 0;

    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    // Clean sweep first so the abort has a pass=1 to clear.
    run_vec(vecs[0], 20);
    // Abort at stim=10 with start held high alongside reset.
    sel = 0; r_stuck = 0; r_hi = 1; r_flip_en = 0;
    @(negedge clk);
    exp1 = 32'hFFFF0000; start1 = 1;
    @(negedge clk);
    start1 = 0; found = 0;
    for (int c = 0; c < 200; c++) begin
      if (sv1 && stim1 == 5'd10) begin found = 1; break; end
      @(negedge clk);
    end
    chk("abort reach_stim10", int'(found), 1);
    rst = 1; start1 = 1;
    @(negedge clk);
    chk_zero("abort");
    rst = 0; start1 = 0;
    n_done = 0;
    for (int c = 0; c < 110; c++) begin
      if (done1 || busy1) n_done++;
      @(negedge clk);
    end
    chk("abort no_done_or_busy", n_done, 0);
    run_vec(vecs[0], 21);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
